// File: rtl/step_pulse_gen.sv
// Step square-wave generator: fixed walk/jog/run paces or a timed multi-segment
// pace profile, with a saturating step counter driven by pulse rising edges.
module step_pulse_gen #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned SEC_DIV   = 100000000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DUR_W     = 8,
  parameter int unsigned WALK_HALF = 1562500,
  parameter int unsigned JOG_HALF  = 781250,
  parameter int unsigned RUN_HALF  = 390625
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [1:0]               MODE,
  input  logic                     prof_we,
  input  logic [$clog2(DEPTH)-1:0] prof_addr,
  input  logic [DUR_W-1:0]         prof_dur,
  input  logic [CNT_W-1:0]         prof_half,
  output logic                     pulse,
  output logic                     step_strobe,
  output logic [STEP_W-1:0]        steps,
  output logic [CNT_W-1:0]         half_period,
  output logic [$clog2(DEPTH)-1:0] seg_idx,
  output logic                     busy,
  output logic                     done
);
  // state   | meaning
  // S_IDLE  | stopped, pulse low, steps held
  // S_FIXED | constant pace from latched MODE 0-2
  // S_PROF  | walking through profile segments, one per prof_dur seconds
  // S_DONE  | profile finished, waiting for START to drop
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FIXED = 2'd1;
  localparam logic [1:0] S_PROF  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SEC_W = $clog2(SEC_DIV);

  logic [DUR_W-1:0]  r_tab_dur  [DEPTH];
  logic [CNT_W-1:0]  r_tab_half [DEPTH];

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_phase;
  logic [CNT_W-1:0]  r_half;
  logic [SEC_W-1:0]  r_sec;
  logic [DUR_W-1:0]  r_dur_left;
  logic [AW-1:0]     r_seg;
  logic              r_pulse;
  logic              r_strobe;
  logic [STEP_W-1:0] r_steps;

  logic              w_busy;
  logic              w_toggle;
  logic              w_rise;
  logic              w_tick;
  logic              w_seg_end;
  logic              w_last_seg;
  logic              w_to_done;
  logic              w_restart;
  logic [AW-1:0]     w_next_seg;
  logic [1:0]        w_entry_state;
  logic [CNT_W-1:0]  w_entry_half;
  logic [DUR_W-1:0]  w_entry_dur;

  // Table has no reset so a profile survives RESET; locked while it is being played.
  always_ff @(posedge CLK) begin
    if (!RESET && prof_we && (r_state != S_PROF)) begin
      r_tab_dur[prof_addr]  <= prof_dur;
      r_tab_half[prof_addr] <= prof_half;
    end
  end

  always_comb begin
    w_busy     = (r_state == S_FIXED) || (r_state == S_PROF);
    w_toggle   = (r_half != '0) && (r_phase == r_half);
    w_rise     = w_toggle && !r_pulse;
    w_tick     = (r_state == S_PROF) && (r_sec == SEC_W'(SEC_DIV - 1));
    w_seg_end  = w_tick && (r_dur_left == DUR_W'(1));
    w_next_seg = r_seg + AW'(1);
    w_last_seg = (r_seg == AW'(DEPTH - 1)) || (r_tab_dur[w_next_seg] == '0);
    w_to_done  = w_seg_end && w_last_seg;
    w_restart  = w_busy && (MODE != r_mode);

    w_entry_state = S_FIXED;
    w_entry_half  = '0;
    w_entry_dur   = '0;
    case (MODE)
      2'd0: w_entry_half = CNT_W'(WALK_HALF);
      2'd1: w_entry_half = CNT_W'(JOG_HALF);
      2'd2: w_entry_half = CNT_W'(RUN_HALF);
      default: begin
        if (r_tab_dur[0] == '0) begin
          w_entry_state = S_DONE;
        end else begin
          w_entry_state = S_PROF;
          w_entry_half  = r_tab_half[0];
          w_entry_dur   = r_tab_dur[0];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_mode     <= 2'd0;
      r_phase    <= CNT_W'(1);
      r_half     <= '0;
      r_sec      <= '0;
      r_dur_left <= '0;
      r_seg      <= '0;
      r_pulse    <= 1'b0;
      r_strobe   <= 1'b0;
      r_steps    <= '0;
    end else begin
      r_strobe <= 1'b0;
      if (!START) begin
        r_state    <= S_IDLE;
        r_phase    <= CNT_W'(1);
        r_half     <= '0;
        r_sec      <= '0;
        r_dur_left <= '0;
        r_seg      <= '0;
        r_pulse    <= 1'b0;
      end else if ((r_state == S_IDLE) || w_restart) begin
        r_state    <= w_entry_state;
        r_mode     <= MODE;
        r_half     <= w_entry_half;
        r_dur_left <= w_entry_dur;
        r_phase    <= CNT_W'(1);
        r_sec      <= '0;
        r_seg      <= '0;
        r_pulse    <= 1'b0;
      end else if (w_busy) begin
        r_phase <= w_toggle ? CNT_W'(1) :
                   ((r_half == '0) ? r_phase : r_phase + CNT_W'(1));
        r_pulse <= r_pulse ^ w_toggle;
        if (w_rise && !w_to_done) begin
          r_strobe <= 1'b1;
          if (r_steps != '1) r_steps <= r_steps + STEP_W'(1);
        end
        if (r_state == S_PROF) begin
          r_sec <= w_tick ? '0 : r_sec + SEC_W'(1);
          if (w_to_done) begin
            r_state <= S_DONE;
            r_pulse <= 1'b0;
            r_half  <= '0;
            r_phase <= CNT_W'(1);
          end else if (w_seg_end) begin
            // pulse level carries across the boundary; only the pace changes
            r_seg      <= w_next_seg;
            r_half     <= r_tab_half[w_next_seg];
            r_dur_left <= r_tab_dur[w_next_seg];
            r_phase    <= CNT_W'(1);
          end else if (w_tick) begin
            r_dur_left <= r_dur_left - DUR_W'(1);
          end
        end
      end else begin
        r_pulse <= 1'b0;
        r_half  <= '0;
      end
    end
  end

  assign pulse       = r_pulse;
  assign step_strobe = r_strobe;
  assign steps       = r_steps;
  assign half_period = r_half;
  assign seg_idx     = r_seg;
  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen with short paces and a 10-cycle second; expected
// strobe times are queued per scenario and popped as strobes appear.
module tb_step_pulse_gen;
  localparam int CNT_W = 16, STEP_W = 4, SEC_DIV = 10, DEPTH = 4, DUR_W = 4;
  localparam int AW = $clog2(DEPTH);

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              START = 1'b0;
  logic [1:0]        MODE = 2'd0;
  logic              prof_we = 1'b0;
  logic [AW-1:0]     prof_addr = '0;
  logic [DUR_W-1:0]  prof_dur = '0;
  logic [CNT_W-1:0]  prof_half = '0;
  logic              pulse, step_strobe, busy, done;
  logic [STEP_W-1:0] steps;
  logic [CNT_W-1:0]  half_period;
  logic [AW-1:0]     seg_idx;

  int n_cmp = 0;
  int n_err = 0;
  int q_exp[$];

  always #5 CLK = ~CLK;

  step_pulse_gen #(
    .CNT_W(CNT_W), .STEP_W(STEP_W), .SEC_DIV(SEC_DIV), .DEPTH(DEPTH), .DUR_W(DUR_W),
    .WALK_HALF(4), .JOG_HALF(3), .RUN_HALF(1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE),
    .prof_we(prof_we), .prof_addr(prof_addr), .prof_dur(prof_dur), .prof_half(prof_half),
    .pulse(pulse), .step_strobe(step_strobe), .steps(steps), .half_period(half_period),
    .seg_idx(seg_idx), .busy(busy), .done(done)
  );

  task automatic do_reset();
    RESET = 1'b1; START = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic write_entry(input int a, input int d, input int h);
    prof_we = 1'b1; prof_addr = AW'(a); prof_dur = DUR_W'(d); prof_half = CNT_W'(h);
    @(negedge CLK);
    prof_we = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; MODE = 2'd0;
    @(negedge CLK); @(negedge CLK);
    n_cmp++;
    if ({pulse, step_strobe, busy, done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {pulse, step_strobe, busy, done});
    end
    n_cmp++;
    if (steps !== '0 || half_period !== '0 || seg_idx !== '0) begin
      n_err++; $display("FAIL reset_values: got steps=%0d half=%0d seg=%0d want 0/0/0", steps, half_period, seg_idx);
    end
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_walk();
    int x;
    do_reset();
    q_exp.delete(); q_exp = '{4, 12, 20};
    MODE = 2'd0; START = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1 || half_period !== 16'd4 || pulse !== 1'b0) begin
      n_err++; $display("FAIL walk_start: got busy=%b half=%0d pulse=%b want 1/4/0", busy, half_period, pulse);
    end
    for (int e = 1; e <= 24; e++) begin
      @(negedge CLK);
      if (step_strobe) begin
        n_cmp++;
        if (q_exp.size() == 0) begin
          n_err++; $display("FAIL walk_strobe: got strobe at edge %0d want none", e);
        end else begin
          x = q_exp.pop_front();
          if (x != e) begin n_err++; $display("FAIL walk_strobe: got edge %0d want edge %0d", e, x); end
        end
      end
    end
    n_cmp++;
    if (q_exp.size() != 0) begin n_err++; $display("FAIL walk_missing: got %0d unseen strobes want 0", q_exp.size()); end
    n_cmp++;
    if (steps !== 4'd3) begin n_err++; $display("FAIL walk_steps: got %0d want 3", steps); end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    do_reset();
    MODE = 2'd0; START = 1'b1;
    @(negedge CLK);
    repeat (13) @(negedge CLK);
    n_cmp++;
    if (steps !== 4'd2) begin n_err++; $display("FAIL rmid_pre: got steps=%0d want 2", steps); end
    RESET = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (steps !== '0 || pulse !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_post: got steps=%0d pulse=%b busy=%b want 0/0/0", steps, pulse, busy);
    end
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_reset_wins: got busy=%b want 0", busy); end
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1 || steps !== '0) begin
      n_err++; $display("FAIL rmid_restart: got busy=%b steps=%0d want 1/0", busy, steps);
    end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_stop_and_mode();
    do_reset();
    MODE = 2'd0; START = 1'b1;
    @(negedge CLK);
    repeat (38) @(negedge CLK);
    n_cmp++;
    if (steps !== 4'd5 || pulse !== 1'b1) begin
      n_err++; $display("FAIL stop_pre: got steps=%0d pulse=%b want 5/1", steps, pulse);
    end
    START = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b0 || pulse !== 1'b0 || steps !== 4'd5) begin
      n_err++; $display("FAIL stop_post: got busy=%b pulse=%b steps=%0d want 0/0/5", busy, pulse, steps);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (steps !== 4'd5) begin n_err++; $display("FAIL stop_hold: got steps=%0d want 5", steps); end
    MODE = 2'd1; START = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (half_period !== 16'd3) begin n_err++; $display("FAIL jog_half: got %0d want 3", half_period); end
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (steps !== 4'd6 || pulse !== 1'b1) begin
      n_err++; $display("FAIL jog_run: got steps=%0d pulse=%b want 6/1", steps, pulse);
    end
    MODE = 2'd2;
    @(negedge CLK);
    n_cmp++;
    if (pulse !== 1'b0 || busy !== 1'b1 || half_period !== 16'd1 || steps !== 4'd6) begin
      n_err++; $display("FAIL mode_restart: got pulse=%b busy=%b half=%0d steps=%0d want 0/1/1/6", pulse, busy, half_period, steps);
    end
    @(negedge CLK);
    n_cmp++;
    if (pulse !== 1'b1 || step_strobe !== 1'b1 || steps !== 4'd7) begin
      n_err++; $display("FAIL mode_first_rise: got pulse=%b strobe=%b steps=%0d want 1/1/7", pulse, step_strobe, steps);
    end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_saturate();
    int ns, prev, wraps;
    ns = 0; prev = 0; wraps = 0;
    do_reset();
    MODE = 2'd2; START = 1'b1;
    @(negedge CLK);
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLK);
      if (step_strobe) ns++;
      if (int'(steps) < prev) wraps++;
      prev = int'(steps);
    end
    n_cmp++;
    if (ns != 20) begin n_err++; $display("FAIL sat_strobes: got %0d want 20", ns); end
    n_cmp++;
    if (steps !== 4'd15) begin n_err++; $display("FAIL sat_steps: got %0d want 15", steps); end
    n_cmp++;
    if (wraps != 0) begin n_err++; $display("FAIL sat_wrap: got %0d wraps want 0", wraps); end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_profile();
    int x;
    do_reset();
    write_entry(0, 2, 2); write_entry(1, 1, 5); write_entry(2, 0, 0); write_entry(3, 1, 1);
    q_exp.delete(); q_exp = '{2, 6, 10, 14, 18, 25};
    MODE = 2'd3; START = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1 || half_period !== 16'd2 || seg_idx !== '0) begin
      n_err++; $display("FAIL prof_start: got busy=%b half=%0d seg=%0d want 1/2/0", busy, half_period, seg_idx);
    end
    for (int e = 1; e <= 30; e++) begin
      @(negedge CLK);
      if (step_strobe) begin
        n_cmp++;
        if (q_exp.size() == 0) begin
          n_err++; $display("FAIL prof_strobe: got strobe at edge %0d want none", e);
        end else begin
          x = q_exp.pop_front();
          if (x != e) begin n_err++; $display("FAIL prof_strobe: got edge %0d want edge %0d", e, x); end
        end
      end
      if (e == 19) begin
        n_cmp++;
        if (steps !== 4'd5 || seg_idx !== '0) begin
          n_err++; $display("FAIL prof_seg0_end: got steps=%0d seg=%0d want 5/0", steps, seg_idx);
        end
      end
      if (e == 20) begin
        n_cmp++;
        if (seg_idx !== 2'd1 || half_period !== 16'd5) begin
          n_err++; $display("FAIL prof_seg1: got seg=%0d half=%0d want 1/5", seg_idx, half_period);
        end
      end
    end
    n_cmp++;
    if (q_exp.size() != 0) begin n_err++; $display("FAIL prof_missing: got %0d unseen strobes want 0", q_exp.size()); end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse !== 1'b0 || half_period !== '0 || steps !== 4'd6) begin
      n_err++; $display("FAIL prof_done: got done=%b busy=%b pulse=%b half=%0d steps=%0d want 1/0/0/0/6", done, busy, pulse, half_period, steps);
    end
    START = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL prof_done_clear: got %b want 0", done); end
  endtask

  task automatic test_profile_end();
    int x;
    do_reset();
    write_entry(0, 1, 3); write_entry(1, 1, 0); write_entry(2, 1, 2); write_entry(3, 1, 4);
    q_exp.delete(); q_exp = '{3, 9, 24, 28, 34};
    MODE = 2'd3; START = 1'b1;
    @(negedge CLK);
    for (int e = 1; e <= 40; e++) begin
      @(negedge CLK);
      if (step_strobe) begin
        n_cmp++;
        if (q_exp.size() == 0) begin
          n_err++; $display("FAIL end_strobe: got strobe at edge %0d want none", e);
        end else begin
          x = q_exp.pop_front();
          if (x != e) begin n_err++; $display("FAIL end_strobe: got edge %0d want edge %0d", e, x); end
        end
      end
      if (e == 15) begin
        n_cmp++;
        if (pulse !== 1'b1 || seg_idx !== 2'd1 || half_period !== '0) begin
          n_err++; $display("FAIL end_silent: got pulse=%b seg=%0d half=%0d want 1/1/0", pulse, seg_idx, half_period);
        end
      end
      if (e == 39) begin
        n_cmp++;
        if (busy !== 1'b1 || seg_idx !== 2'd3) begin
          n_err++; $display("FAIL end_last_seg: got busy=%b seg=%0d want 1/3", busy, seg_idx);
        end
      end
    end
    n_cmp++;
    if (q_exp.size() != 0) begin n_err++; $display("FAIL end_missing: got %0d unseen strobes want 0", q_exp.size()); end
    n_cmp++;
    if (done !== 1'b1 || pulse !== 1'b0) begin
      n_err++; $display("FAIL end_done: got done=%b pulse=%b want 1/0", done, pulse);
    end
    write_entry(0, 0, 5);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_prof: got done=%b busy=%b want 1/0", done, busy);
    end
    START = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_write_lock();
    do_reset();
    write_entry(0, 3, 2); write_entry(1, 2, 7); write_entry(2, 0, 0);
    MODE = 2'd3; START = 1'b1;
    @(negedge CLK);
    write_entry(1, 1, 3);
    repeat (29) @(negedge CLK);
    n_cmp++;
    if (seg_idx !== 2'd1 || half_period !== 16'd7) begin
      n_err++; $display("FAIL lock_half: got seg=%0d half=%0d want 1/7", seg_idx, half_period);
    end
    repeat (15) @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1 || seg_idx !== 2'd1) begin
      n_err++; $display("FAIL lock_dur: got busy=%b seg=%0d want 1/1", busy, seg_idx);
    end
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL lock_done: got %b want 1", done); end
    START = 1'b0;
    @(negedge CLK);
    write_entry(1, 1, 3);
    START = 1'b1;
    @(negedge CLK);
    repeat (30) @(negedge CLK);
    n_cmp++;
    if (seg_idx !== 2'd1 || half_period !== 16'd3) begin
      n_err++; $display("FAIL idle_write_half: got seg=%0d half=%0d want 1/3", seg_idx, half_period);
    end
    repeat (10) @(negedge CLK);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL idle_write_done: got %b want 1", done); end
    START = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_walk();
    test_reset_mid();
    test_stop_and_mode();
    test_saturate();
    test_profile();
    test_profile_end();
    test_write_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
